pipeline_stage_register: RTL and testbench
==========================================

# pipeline_stage_register

Parametrised successor to the fixed fetch/decode stage register: a generic inter-stage pipeline register with a valid/ready handshake, synchronous flush, and an optional one-entry skid buffer. It carries an arbitrary-width payload plus a HALT sideband bit, so the same block serves every stage boundary (F/D, D/E, E/M, M/W). Unlike the fixed register, it holds data under backpressure and registers `in_ready`, without needing a stall wire driven by the hazard unit.

## Interface
- `WIDTH`, 32: payload width in bits (≥1).
- `RESET_VALUE`, `{WIDTH{1'b0}}`: `out_data` value after reset (F/D instance uses `32'hBFC00004`).
- `CLEAR_VALUE`, `{WIDTH{1'b0}}`: `out_data` value after flush.
- `SKID`, 1: 1 = two-entry skid buffer with registered `in_ready`; 0 = single entry with combinational `in_ready`.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `flush`  in  1  synchronous clear of all held entries (branch/jump squash).
- `in_valid`  in  1  upstream entry present.
- `in_ready`  out  1  block accepts the entry this cycle.
- `in_data`  in  WIDTH  upstream payload.
- `in_halt`  in  1  HALT sideband travelling with the payload.
- `out_valid`  out  1  downstream entry present.
- `out_ready`  in  1  downstream consumes the entry this cycle.
- `out_data`  out  WIDTH  registered payload.
- `out_halt`  out  1  registered HALT sideband.
- `occupancy`  out  2  number of held entries (0..2; max 1 when SKID=0).

## Operation
- Handshakes: in-fire = `in_valid & in_ready`; out-fire = `out_valid & out_ready`. `in_data` and `in_halt` are sampled only on in-fire.
- The state machine (SKID=1) is encoded by occupancy, and the next state is resolved per `clk` edge.
  - EMPTY: `in_ready`=1, `out_valid`=0. On in-fire, load main with `in_data`/`in_halt` and go to ONE.
  - ONE: `in_ready`=1, `out_valid`=1.
    - in-fire & out-fire: load main from input and stay in ONE.
    - out-fire only: go to EMPTY.
    - in-fire only: load skid from input and go to TWO.
    - neither: hold.
  - TWO: `in_ready`=0, `out_valid`=1. On out-fire, move skid into main and go to ONE. Otherwise hold.
- SKID=0: only EMPTY and ONE exist. `in_ready = !out_valid | out_ready`. ONE with in-fire and no out-fire cannot occur.
- Flush: next state is EMPTY. `out_data` becomes CLEAR_VALUE, `out_halt`=0 and the skid entry is cleared. Flush beats any same-cycle in-fire, and that input is discarded; upstream sees it as consumed.
- Priority: `reset` > `flush` > handshake.
- Reset: `out_valid`=0, `out_data`=RESET_VALUE, `out_halt`=0, `occupancy`=0, `in_ready`=1 in the cycle after reset deasserts. Reset mid-operation discards both entries.
- Ordering: entries leave in acceptance order. No loss or duplication except by flush.
- While `out_valid`=0, `out_data`/`out_halt` hold their last value (RESET_VALUE, CLEAR_VALUE, or the last consumed payload). Consumers must qualify with `out_valid`.

## Timing
- Latency: 1 cycle from in-fire to `out_valid`/`out_data`.
- Throughput: 1 entry per cycle when `out_ready` is held high.
- SKID=1: `in_ready` is a pure register output (state != TWO). It has no combinational path from `out_ready`.
- SKID=0: `in_ready` depends combinationally on `out_ready` in the same cycle.
- `out_*` and `occupancy` are registered and have no combinational path from any input.
- A stall costs 0 lost cycles: on release, the held entry goes out on the first cycle `out_ready`=1, and the skid entry goes out on the following cycle.

## Structure
- Shared package `pipeline_pkg`:
  - state enum `stage_state_t` {EMPTY, ONE, TWO};
  - constant `RESET_PC = 32'hBFC00004`.
- Single module. No sub-module: the main and skid entries are two register sets sharing one next-state block. The skid storage is generated only when SKID=1.

## Test plan
1. **Reset:** assert `reset` for 2 cycles with WIDTH=32, RESET_VALUE=`32'hBFC00004`. Required: `out_valid`=0, `out_data`=`32'hBFC00004`, `out_halt`=0, `occupancy`=0, `in_ready`=1.
2. **Streaming:** hold `out_ready`=1 and send `in_data` = 0x10, 0x14, 0x18 on consecutive cycles. Required: `out_data` shows 0x10, 0x14, 0x18 one cycle later each, `occupancy` stays at 1, no bubbles.
3. **Backpressure (SKID=1):** with `out_ready`=0, send 0xA then 0xB. Required: `occupancy`=2 and `in_ready`=0 from the cycle after 0xB is accepted. Then raise `out_ready`. Required: 0xA then 0xB on consecutive cycles, and `in_ready` returns to 1 one cycle after the first out-fire.
4. **Flush with input:** with TWO held, assert `flush` with `in_valid`=1 and `in_data`=0xC. Required next cycle: `out_valid`=0, `out_data`=CLEAR_VALUE, `occupancy`=0. 0xC never appears at the output.
5. **HALT sideband:** send 0x20 with `in_halt`=1 under backpressure. Required: `out_halt`=1 stays aligned with 0x20 through the skid→main move, then 0 on the next entry.
6. **SKID=0 variant:** with `out_valid`=1, toggle `out_ready` 1→0. Required: `in_ready` follows it in the same cycle, and `occupancy` never exceeds 1.

Source files
------------

// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared types and constants for pipeline stage registers
package pipeline_pkg;

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stage_state_t;

  localparam logic [31:0] RESET_PC = 32'hBFC00004;

endpackage

// File: rtl/pipeline_stage_register.sv
// rtl/pipeline_stage_register.sv - valid/ready stage register with flush and optional skid entry
module pipeline_stage_register
  import pipeline_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [WIDTH-1:0] CLEAR_VALUE = '0,
  parameter bit               SKID        = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_halt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_halt,
  output logic [1:0]       occupancy
);

  stage_state_t     state_q, state_d;
  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic             main_halt_q, main_halt_d;
  logic [WIDTH-1:0] skid_data;
  logic             skid_halt;
  logic             skid_load;
  logic             in_fire, out_fire;

  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_data_q;
  assign out_halt  = main_halt_q;
  assign occupancy = state_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_halt_d = main_halt_q;
    skid_load   = 1'b0;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          main_data_d = in_data;
          main_halt_d = in_halt;
          state_d     = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_data_d = in_data;
          main_halt_d = in_halt;
        end else if (out_fire) begin
          state_d = EMPTY;
        end else if (in_fire && SKID) begin
          skid_load = 1'b1;
          state_d   = TWO;
        end
      end
      TWO: begin
        if (out_fire) begin
          main_data_d = skid_data;
          main_halt_d = skid_halt;
          state_d     = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush squashes everything, including an input accepted this same cycle.
    if (flush) begin
      state_d     = EMPTY;
      main_data_d = CLEAR_VALUE;
      main_halt_d = 1'b0;
      skid_load   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= EMPTY;
      main_data_q <= RESET_VALUE;
      main_halt_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_halt_q <= main_halt_d;
    end
  end

  if (SKID) begin : g_skid
    logic [WIDTH-1:0] skid_data_q;
    logic             skid_halt_q;
    logic             in_ready_q;

    always_ff @(posedge clk) begin
      if (reset || flush) begin
        skid_data_q <= '0;
        skid_halt_q <= 1'b0;
      end else if (skid_load) begin
        skid_data_q <= in_data;
        skid_halt_q <= in_halt;
      end
    end

    // Precomputed from next state so in_ready never sees out_ready combinationally.
    always_ff @(posedge clk) begin
      if (reset) begin
        in_ready_q <= 1'b1;
      end else begin
        in_ready_q <= (state_d != TWO);
      end
    end

    assign skid_data = skid_data_q;
    assign skid_halt = skid_halt_q;
    assign in_ready  = in_ready_q;
  end else begin : g_no_skid
    assign skid_data = '0;
    assign skid_halt = 1'b0;
    assign in_ready  = !out_valid | out_ready;
  end

endmodule

// File: tb/tb_pipeline_stage_register.sv
// tb/tb_pipeline_stage_register.sv - directed self-checking bench for pipeline_stage_register
module tb_pipeline_stage_register;
  import pipeline_pkg::*;

  localparam logic [31:0] CLR = 32'h0000_0013;

  logic clk = 1'b0;
  logic reset, flush;
  int total = 0;
  int bad   = 0;

  logic        in_valid1, in_ready1, in_halt1, out_valid1, out_ready1, out_halt1;
  logic [31:0] in_data1, out_data1;
  logic [1:0]  occ1;

  logic        in_valid0, in_ready0, in_halt0, out_valid0, out_ready0, out_halt0;
  logic [31:0] in_data0, out_data0;
  logic [1:0]  occ0;

  always #5 clk = ~clk;

  pipeline_stage_register #(.WIDTH(32), .RESET_VALUE(RESET_PC), .CLEAR_VALUE(CLR), .SKID(1'b1)) dut1 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1), .in_halt(in_halt1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1), .out_halt(out_halt1),
    .occupancy(occ1)
  );

  pipeline_stage_register #(.WIDTH(32), .SKID(1'b0)) dut0 (
    .clk(clk), .reset(reset), .flush(1'b0),
    .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0), .in_halt(in_halt0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0), .out_halt(out_halt0),
    .occupancy(occ0)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send1(input logic [31:0] d, input logic h);
    in_valid1 = 1'b1; in_data1 = d; in_halt1 = h;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0;
    in_valid1 = 0; in_data1 = '0; in_halt1 = 0; out_ready1 = 0;
    in_valid0 = 0; in_data0 = '0; in_halt0 = 0; out_ready0 = 0;
    step(); step();
    reset = 1'b0;
    total++; if (out_valid1 !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", out_valid1); end
    total++; if (out_data1 !== 32'hBFC00004) begin bad++; $display("FAIL reset_data got=%h want=bfc00004", out_data1); end
    total++; if (out_halt1 !== 1'b0) begin bad++; $display("FAIL reset_halt got=%0b want=0", out_halt1); end
    total++; if (occ1 !== 2'd0) begin bad++; $display("FAIL reset_occ got=%0d want=0", occ1); end
    total++; if (in_ready1 !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b want=1", in_ready1); end
    total++; if (out_data0 !== 32'h0) begin bad++; $display("FAIL reset_data0 got=%h want=0", out_data0); end
    step();
    total++; if (in_ready1 !== 1'b1 || occ1 !== 2'd0) begin bad++; $display("FAIL reset_after_rdy got=%0b/%0d want=1/0", in_ready1, occ1); end
  endtask

  task automatic test_streaming();
    logic [31:0] vec [3];
    vec[0] = 32'h10; vec[1] = 32'h14; vec[2] = 32'h18;
    out_ready1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send1(vec[i], 1'b0);
      step();
      total++; if (out_valid1 !== 1'b1 || out_data1 !== vec[i]) begin bad++; $display("FAIL stream_%0d got=%0b/%h want=1/%h", i, out_valid1, out_data1, vec[i]); end
      total++; if (occ1 !== 2'd1 || in_ready1 !== 1'b1) begin bad++; $display("FAIL stream_occ_%0d got=%0d/%0b want=1/1", i, occ1, in_ready1); end
    end
    in_valid1 = 1'b0;
    step();
    total++; if (out_valid1 !== 1'b0 || occ1 !== 2'd0) begin bad++; $display("FAIL stream_drain got=%0b/%0d want=0/0", out_valid1, occ1); end
    total++; if (out_data1 !== 32'h18) begin bad++; $display("FAIL stream_hold got=%h want=18", out_data1); end
  endtask

  task automatic test_backpressure();
    out_ready1 = 1'b0;
    send1(32'hA, 1'b0);
    step();
    total++; if (occ1 !== 2'd1 || in_ready1 !== 1'b1 || out_data1 !== 32'hA) begin bad++; $display("FAIL bp_first got=%0d/%0b/%h want=1/1/a", occ1, in_ready1, out_data1); end
    send1(32'hB, 1'b0);
    step();
    in_valid1 = 1'b0;
    total++; if (occ1 !== 2'd2 || in_ready1 !== 1'b0) begin bad++; $display("FAIL bp_full got=%0d/%0b want=2/0", occ1, in_ready1); end
    total++; if (out_data1 !== 32'hA) begin bad++; $display("FAIL bp_head got=%h want=a", out_data1); end
    step();
    total++; if (occ1 !== 2'd2 || out_data1 !== 32'hA) begin bad++; $display("FAIL bp_hold got=%0d/%h want=2/a", occ1, out_data1); end
    out_ready1 = 1'b1;
    step();
    total++; if (out_valid1 !== 1'b1 || out_data1 !== 32'hB) begin bad++; $display("FAIL bp_second got=%0b/%h want=1/b", out_valid1, out_data1); end
    total++; if (in_ready1 !== 1'b1 || occ1 !== 2'd1) begin bad++; $display("FAIL bp_release got=%0b/%0d want=1/1", in_ready1, occ1); end
    step();
    total++; if (out_valid1 !== 1'b0 || occ1 !== 2'd0) begin bad++; $display("FAIL bp_empty got=%0b/%0d want=0/0", out_valid1, occ1); end
  endtask

  task automatic test_flush();
    out_ready1 = 1'b0;
    send1(32'h1, 1'b1); step();
    send1(32'h2, 1'b1); step();
    total++; if (occ1 !== 2'd2) begin bad++; $display("FAIL flush_setup got=%0d want=2", occ1); end
    send1(32'hC, 1'b0); flush = 1'b1;
    step();
    flush = 1'b0; in_valid1 = 1'b0;
    total++; if (out_valid1 !== 1'b0 || occ1 !== 2'd0) begin bad++; $display("FAIL flush_two got=%0b/%0d want=0/0", out_valid1, occ1); end
    total++; if (out_data1 !== CLR || out_halt1 !== 1'b0) begin bad++; $display("FAIL flush_clear got=%h/%0b want=%h/0", out_data1, out_halt1, CLR); end
    total++; if (in_ready1 !== 1'b1) begin bad++; $display("FAIL flush_rdy got=%0b want=1", in_ready1); end
    out_ready1 = 1'b1;
    step(); step();
    total++; if (out_valid1 !== 1'b0 || out_data1 !== CLR) begin bad++; $display("FAIL flush_no_c got=%0b/%h want=0/%h", out_valid1, out_data1, CLR); end
    // Flush from ONE while the input really fires: input must still be dropped.
    send1(32'h5, 1'b0); step();
    send1(32'hD, 1'b0); flush = 1'b1;
    step();
    flush = 1'b0; in_valid1 = 1'b0;
    total++; if (out_valid1 !== 1'b0 || occ1 !== 2'd0 || out_data1 !== CLR) begin bad++; $display("FAIL flush_one got=%0b/%0d/%h want=0/0/%h", out_valid1, occ1, out_data1, CLR); end
  endtask

  task automatic test_halt();
    out_ready1 = 1'b0;
    send1(32'h1F, 1'b0); step();
    send1(32'h20, 1'b1); step();
    in_valid1 = 1'b0;
    total++; if (out_data1 !== 32'h1F || out_halt1 !== 1'b0) begin bad++; $display("FAIL halt_head got=%h/%0b want=1f/0", out_data1, out_halt1); end
    out_ready1 = 1'b1;
    step();
    total++; if (out_data1 !== 32'h20 || out_halt1 !== 1'b1) begin bad++; $display("FAIL halt_moved got=%h/%0b want=20/1", out_data1, out_halt1); end
    send1(32'h21, 1'b0);
    step();
    in_valid1 = 1'b0;
    total++; if (out_data1 !== 32'h21 || out_halt1 !== 1'b0 || out_valid1 !== 1'b1) begin bad++; $display("FAIL halt_next got=%h/%0b/%0b want=21/0/1", out_data1, out_halt1, out_valid1); end
    step();
  endtask

  task automatic test_skid0();
    in_valid0 = 1'b1; in_data0 = 32'h30; out_ready0 = 1'b1;
    step();
    total++; if (out_valid0 !== 1'b1 || out_data0 !== 32'h30 || occ0 !== 2'd1) begin bad++; $display("FAIL s0_load got=%0b/%h/%0d want=1/30/1", out_valid0, out_data0, occ0); end
    in_data0 = 32'h31;
    total++; if (in_ready0 !== 1'b1) begin bad++; $display("FAIL s0_rdy_hi got=%0b want=1", in_ready0); end
    out_ready0 = 1'b0; #1;
    total++; if (in_ready0 !== 1'b0) begin bad++; $display("FAIL s0_rdy_lo got=%0b want=0", in_ready0); end
    step();
    total++; if (occ0 !== 2'd1 || out_data0 !== 32'h30) begin bad++; $display("FAIL s0_stall got=%0d/%h want=1/30", occ0, out_data0); end
    out_ready0 = 1'b1; #1;
    total++; if (in_ready0 !== 1'b1) begin bad++; $display("FAIL s0_rdy_back got=%0b want=1", in_ready0); end
    step();
    in_valid0 = 1'b0;
    total++; if (occ0 !== 2'd1 || out_data0 !== 32'h31) begin bad++; $display("FAIL s0_next got=%0d/%h want=1/31", occ0, out_data0); end
    step();
    total++; if (occ0 !== 2'd0 || out_valid0 !== 1'b0 || in_ready0 !== 1'b1) begin bad++; $display("FAIL s0_empty got=%0d/%0b/%0b want=0/0/1", occ0, out_valid0, in_ready0); end
  endtask

  task automatic test_reset_mid();
    out_ready1 = 1'b0;
    send1(32'h40, 1'b1); step();
    send1(32'h44, 1'b1); step();
    in_valid1 = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0;
    total++; if (occ1 !== 2'd0 || out_valid1 !== 1'b0 || out_data1 !== RESET_PC || out_halt1 !== 1'b0 || in_ready1 !== 1'b1) begin
      bad++; $display("FAIL reset_mid got=%0d/%0b/%h/%0b/%0b want=0/0/bfc00004/0/1", occ1, out_valid1, out_data1, out_halt1, in_ready1);
    end
    out_ready1 = 1'b1;
    step();
    total++; if (out_valid1 !== 1'b0) begin bad++; $display("FAIL reset_mid_drop got=%0b want=0", out_valid1); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_halt();
    test_skid0();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
